// File: rtl/hood_pkg.sv
// Shared types and constants for the range-hood fan controller.
// Holds the state encoding, the BCD mm:ss types and a constant seconds-to-mm:ss helper.
package hood_pkg;

  localparam int DEF_TICK_DIV   = 500;
  localparam int DEF_NUM_LEVELS = 2;
  localparam int DEF_BOOST_SEC  = 60;
  localparam int DEF_CLEAN_MIN  = 10;

  // Controller state encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_STANDBY = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_BOOST   = 2'd2;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t m1;
    bcd_digit_t m0;
    bcd_digit_t s1;
    bcd_digit_t s0;
  } mmss_t;

  // Only ever evaluated on elaboration constants.
  function automatic mmss_t sec_to_mmss(input int unsigned secs);
    mmss_t       r;
    int unsigned mins;
    int unsigned rem;
    mins = secs / 60;
    rem  = secs % 60;
    r.m1 = bcd_digit_t'(mins / 10);
    r.m0 = bcd_digit_t'(mins % 10);
    r.s1 = bcd_digit_t'(rem / 10);
    r.s0 = bcd_digit_t'(rem % 10);
    return r;
  endfunction

endpackage

// File: rtl/hood_mmss_counter.sv
// BCD mm:ss counter with clear > load > up > down priority.
// Counting up wraps 99:59 to 00:00; counting down holds at 00:00.
module hood_mmss_counter
  import hood_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  load,
  input  mmss_t load_val,
  input  logic  up,
  input  logic  down,
  output mmss_t value
);

  mmss_t value_reg;
  mmss_t value_next;
  mmss_t inc_val;
  mmss_t dec_val;

  always_comb begin
    inc_val = value_reg;
    if (value_reg.s0 != 4'd9) begin
      inc_val.s0 = value_reg.s0 + 4'd1;
    end else begin
      inc_val.s0 = 4'd0;
      if (value_reg.s1 != 4'd5) begin
        inc_val.s1 = value_reg.s1 + 4'd1;
      end else begin
        inc_val.s1 = 4'd0;
        if (value_reg.m0 != 4'd9) begin
          inc_val.m0 = value_reg.m0 + 4'd1;
        end else begin
          inc_val.m0 = 4'd0;
          inc_val.m1 = (value_reg.m1 == 4'd9) ? 4'd0 : value_reg.m1 + 4'd1;
        end
      end
    end
  end

  always_comb begin
    dec_val = value_reg;
    if (value_reg == '0) begin
      dec_val = '0;
    end else if (value_reg.s0 != 4'd0) begin
      dec_val.s0 = value_reg.s0 - 4'd1;
    end else begin
      dec_val.s0 = 4'd9;
      if (value_reg.s1 != 4'd0) begin
        dec_val.s1 = value_reg.s1 - 4'd1;
      end else begin
        dec_val.s1 = 4'd5;
        if (value_reg.m0 != 4'd0) begin
          dec_val.m0 = value_reg.m0 - 4'd1;
        end else begin
          dec_val.m0 = 4'd9;
          dec_val.m1 = value_reg.m1 - 4'd1;
        end
      end
    end
  end

  always_comb begin
    value_next = value_reg;
    if (clr) begin
      value_next = '0;
    end else if (load) begin
      value_next = load_val;
    end else if (up) begin
      value_next = inc_val;
    end else if (down) begin
      value_next = dec_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/hood_fan_ctrl.sv
// Range-hood fan controller: standby/run/boost FSM, one-shot timed boost,
// runtime accumulation with a sticky cleaning reminder and a 4-digit BCD display.
module hood_fan_ctrl
  import hood_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int BOOST_SEC  = DEF_BOOST_SEC,
  parameter int CLEAN_MIN  = DEF_CLEAN_MIN,
  localparam int LW        = $clog2(NUM_LEVELS + 2)
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          level_req_valid,
  input  logic [LW-1:0] level_req,
  input  logic          boost_req,
  input  logic          clean_clr,
  output logic [LW-1:0] fan_level,
  output logic          boost_active,
  output logic          boost_avail,
  output logic          disp_sel,
  output logic [15:0]   disp_bcd,
  output logic          clean_alarm,
  output logic          tick
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LVL_MAX    = LW'(NUM_LEVELS);
  localparam logic [LW-1:0] LVL_BOOST  = LW'(NUM_LEVELS + 1);
  localparam mmss_t         BOOST_VAL  = sec_to_mmss(BOOST_SEC);
  localparam mmss_t         CD_LAST    = sec_to_mmss(1);
  // Runtime value one tick before the minutes reach CLEAN_MIN.
  localparam mmss_t         CLEAN_PRE  = sec_to_mmss(CLEAN_MIN * 60 - 1);

  logic [PW-1:0] presc_reg;
  state_t        state_reg;
  state_t        state_next;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic [LW-1:0] fan_level_reg;
  logic [LW-1:0] fan_level_next;
  logic          avail_reg;
  logic          avail_next;
  logic          alarm_reg;

  logic  in_boost;
  logic  cmd_stop;
  logic  cmd_boost;
  logic  cmd_level;
  logic  expire;
  logic  cd_clr;
  logic  cd_load;
  logic  cd_down;
  logic  rt_up;
  mmss_t cd_value;
  mmss_t rt_value;

  assign tick = (presc_reg == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  assign in_boost  = (state_reg == ST_BOOST);
  assign cmd_stop  = level_req_valid && (level_req == '0);
  assign cmd_boost = boost_req && avail_reg && !in_boost;
  assign cmd_level = level_req_valid && (level_req != '0) && (level_req <= LVL_MAX) && !in_boost;
  // Tick effects use the registered state, so a same-cycle command cannot hide them.
  assign expire    = in_boost && tick && (cd_value == CD_LAST);
  assign cd_down   = in_boost && tick;
  assign rt_up     = tick && ((state_reg == ST_RUN) || in_boost);

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    avail_next = avail_reg;
    cd_clr     = 1'b0;
    cd_load    = 1'b0;
    if (expire) begin
      state_next = ST_RUN;
      level_next = LVL_MAX;
      cd_clr     = 1'b1;
    end
    if (cmd_stop) begin
      state_next = ST_STANDBY;
      level_next = '0;
      cd_clr     = 1'b1;
    end else if (cmd_boost) begin
      state_next = ST_BOOST;
      avail_next = 1'b0;
      cd_load    = 1'b1;
    end else if (cmd_level) begin
      state_next = ST_RUN;
      level_next = level_req;
    end
  end

  always_comb begin
    fan_level_next = '0;
    case (state_next)
      ST_RUN:   fan_level_next = level_next;
      ST_BOOST: fan_level_next = LVL_BOOST;
      default:  fan_level_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_STANDBY;
      level_reg     <= '0;
      fan_level_reg <= '0;
      avail_reg     <= 1'b1;
    end else begin
      state_reg     <= state_next;
      level_reg     <= level_next;
      fan_level_reg <= fan_level_next;
      avail_reg     <= avail_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clean_clr) begin
      alarm_reg <= 1'b0;
    end else if (rt_up && (rt_value == CLEAN_PRE)) begin
      alarm_reg <= 1'b1;
    end
  end

  hood_mmss_counter u_runtime (
    .clk      (clk),
    .rst      (rst),
    .clr      (clean_clr),
    .load     (1'b0),
    .load_val ('0),
    .up       (rt_up),
    .down     (1'b0),
    .value    (rt_value)
  );

  hood_mmss_counter u_countdown (
    .clk      (clk),
    .rst      (rst),
    .clr      (cd_clr),
    .load     (cd_load),
    .load_val (BOOST_VAL),
    .up       (1'b0),
    .down     (cd_down),
    .value    (cd_value)
  );

  assign fan_level    = fan_level_reg;
  assign boost_active = in_boost;
  assign boost_avail  = avail_reg;
  assign disp_sel     = in_boost;
  assign disp_bcd     = in_boost ? cd_value : rt_value;
  assign clean_alarm  = alarm_reg;

endmodule

// File: tb/tb_hood_fan_ctrl.sv
// Directed bench for hood_fan_ctrl with a cycle model in plain seconds and a
// scoreboard queue of expected outputs compared after each clock edge.
module tb_hood_fan_ctrl;

  localparam int TD = 4;
  localparam int NL = 3;
  localparam int BS = 5;
  localparam int CM = 1;
  localparam int LW = 3;

  bit          clk = 1'b0;
  logic        rst;
  logic        lrv;
  logic [LW-1:0] lr;
  logic        br;
  logic        cc;
  logic [LW-1:0] fan_level;
  logic        boost_active;
  logic        boost_avail;
  logic        disp_sel;
  logic [15:0] disp_bcd;
  logic        clean_alarm;
  logic        tick;

  always #5 clk = ~clk;

  hood_fan_ctrl #(
    .TICK_DIV   (TD),
    .NUM_LEVELS (NL),
    .BOOST_SEC  (BS),
    .CLEAN_MIN  (CM)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .level_req_valid (lrv),
    .level_req       (lr),
    .boost_req       (br),
    .clean_clr       (cc),
    .fan_level       (fan_level),
    .boost_active    (boost_active),
    .boost_avail     (boost_avail),
    .disp_sel        (disp_sel),
    .disp_bcd        (disp_bcd),
    .clean_alarm     (clean_alarm),
    .tick            (tick)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // Model state: 0 standby, 1 run, 2 boost; counters held as plain seconds.
  int m_presc = 0;
  int m_state = 0;
  int m_lvl   = 0;
  int m_avail = 1;
  int m_cd    = 0;
  int m_rt    = 0;
  int m_alarm = 0;

  function automatic logic [15:0] to_bcd(input int secs);
    int m;
    int s;
    m = secs / 60;
    s = secs % 60;
    return 16'(((m / 10) << 12) | ((m % 10) << 8) | ((s / 10) << 4) | (s % 10));
  endfunction

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      0: return 16'(fan_level);
      1: return 16'(boost_active);
      2: return 16'(boost_avail);
      3: return 16'(disp_sel);
      4: return disp_bcd;
      5: return 16'(clean_alarm);
      default: return 16'(tick);
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "fan_level";
      1: return "boost_active";
      2: return "boost_avail";
      3: return "disp_sel";
      4: return "disp_bcd";
      5: return "clean_alarm";
      default: return "tick";
    endcase
  endfunction

  task automatic push(input int sel, input logic [15:0] exp);
    exp_t e;
    e.tag = {phase, "/", sel_name(sel)};
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t        e;
      logic [15:0] o;
      e = sb.pop_front();
      o = obs(e.sel);
      total++;
      assert (o === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic check_now(input int sel, input logic [15:0] exp);
    push(sel, exp);
    drain();
  endtask

  // Advance one clock; the model consumes the inputs currently driven.
  task automatic step(input bit chk);
    int tk;
    int np, ns, nl, na, ncd, nrt, nal;
    if (rst) begin
      np = 0; ns = 0; nl = 0; na = 1; ncd = 0; nrt = 0; nal = 0;
    end else begin
      tk  = (m_presc == TD - 1) ? 1 : 0;
      np  = tk ? 0 : m_presc + 1;
      ns  = m_state; nl = m_lvl; na = m_avail; ncd = m_cd;
      nrt = m_rt; nal = m_alarm;
      if (tk && m_state == 2) begin
        if (m_cd == 1) begin
          ns = 1; nl = NL; ncd = 0;
        end else begin
          ncd = m_cd - 1;
        end
      end
      if (lrv && lr == 0) begin
        ns = 0; nl = 0; ncd = 0;
      end else if (br && m_avail == 1 && m_state != 2) begin
        ns = 2; ncd = BS; na = 0;
      end else if (lrv && int'(lr) <= NL && m_state != 2) begin
        ns = 1; nl = int'(lr);
      end
      if (cc) begin
        nrt = 0; nal = 0;
      end else if (tk && m_state != 0) begin
        nrt = (m_rt + 1) % 6000;
        if (nrt == CM * 60) nal = 1;
      end
    end
    if (chk) begin
      push(0, 16'((ns == 0) ? 0 : (ns == 1) ? nl : NL + 1));
      push(1, 16'(ns == 2));
      push(2, 16'(na));
      push(3, 16'(ns == 2));
      push(4, (ns == 2) ? to_bcd(ncd) : to_bcd(nrt));
      push(5, 16'(nal));
      push(6, 16'(np == TD - 1));
    end
    @(posedge clk);
    #1;
    m_presc = np; m_state = ns; m_lvl = nl; m_avail = na;
    m_cd = ncd; m_rt = nrt; m_alarm = nal;
    if (chk) drain();
  endtask

  // Step until the next edge is a tick edge.
  task automatic to_tick(input bit chk);
    for (int g = 0; g < 2 * TD && m_presc != TD - 1; g++) step(chk);
  endtask

  task automatic run_ticks(input int n, input bit chk);
    for (int i = 0; i < n; i++) begin
      to_tick(chk);
      step(chk);
    end
  endtask

  initial begin
    rst = 1'b1; lrv = 1'b0; lr = '0; br = 1'b0; cc = 1'b0;

    phase = "reset";
    step(1);
    step(1);
    rst = 1'b0;

    phase = "run61";
    lrv = 1'b1; lr = 3'd2;
    step(1);
    lrv = 1'b0;
    run_ticks(61, 1);
    check_now(0, 16'd2);
    check_now(4, 16'h0101);
    check_now(5, 16'd1);

    phase = "stop_run_tick";
    to_tick(1);
    lrv = 1'b1; lr = 3'd0; br = 1'b1;
    step(1);
    lrv = 1'b0; br = 1'b0;
    check_now(0, 16'd0);
    check_now(2, 16'd1);
    check_now(4, 16'h0102);

    phase = "stop_sb_tick";
    to_tick(1);
    lrv = 1'b1; lr = 3'd0; br = 1'b1;
    step(1);
    lrv = 1'b0; br = 1'b0;
    check_now(4, 16'h0102);

    phase = "boost";
    lrv = 1'b1; lr = 3'd1;
    step(1);
    lrv = 1'b0;
    step(1);
    br = 1'b1;
    step(1);
    br = 1'b0;
    check_now(0, 16'd4);
    check_now(4, 16'h0005);
    run_ticks(5, 1);
    check_now(0, 16'd3);
    check_now(2, 16'd0);
    check_now(3, 16'd0);

    phase = "reboost";
    br = 1'b1;
    step(1);
    br = 1'b0;
    check_now(0, 16'd3);
    lrv = 1'b1; lr = 3'd5;
    step(1);
    lrv = 1'b0;
    check_now(0, 16'd3);

    phase = "rst_mid_boost";
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    lrv = 1'b1; lr = 3'd1;
    step(1);
    lrv = 1'b0; br = 1'b1;
    step(1);
    br = 1'b0;
    run_ticks(1, 1);
    lrv = 1'b1; lr = 3'd3;
    step(1);
    lrv = 1'b0;
    check_now(0, 16'd4);
    run_ticks(1, 1);
    check_now(4, 16'h0003);
    rst = 1'b1; lrv = 1'b1; lr = 3'd2; br = 1'b1;
    step(1);
    rst = 1'b0; lrv = 1'b0; br = 1'b0;
    check_now(0, 16'd0);
    check_now(2, 16'd1);
    check_now(4, 16'h0000);
    check_now(6, 16'd0);

    phase = "wrap";
    lrv = 1'b1; lr = 3'd2;
    step(1);
    lrv = 1'b0;
    for (int g = 0; g < 30000 && m_rt != 5999; g++) step(0);
    check_now(4, 16'h9959);
    check_now(5, 16'd1);
    run_ticks(1, 1);
    check_now(4, 16'h0000);
    step(1);
    step(1);
    to_tick(1);
    cc = 1'b1;
    step(1);
    cc = 1'b0;
    check_now(4, 16'h0000);
    check_now(5, 16'd0);
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
